gpsreceiver2_bufctl: RTL and testbench
======================================

// Module: gpsreceiver2_bufctl
// PURPOSE
// Capture controller for the GPS receiver sample RAM (2048 bytes, written at byte granularity).
// Runs the RAM as two 1024-byte ping-pong halves. Places each sample byte from the rx front-end at the next address.
// Tracks which halves are full, raises an interrupt to the CPU and stalls, counting dropped samples, when both halves are unread.
// Sits between gpsreceiver2_rx (sample strobe, already in sys_clk domain) and the RAM write port of gpsreceiver2_memory.
// PARAMETERS
// csr_addr   5'h0   CSR bank select, compared against csr_a[14:10]
// PORTS
// sys_clk    in   1   system clock; everything here is in this domain
// sys_rst    in   1   synchronous, active-high reset
// csr_a      in   15  CSR address; [14:10] bank, [1:0] register
// csr_we     in   1   CSR write strobe
// csr_di     in   32  CSR write data
// csr_do     out  32  CSR read data, registered
// smp_dat    in   8   sample byte from rx
// smp_stb    in   1   one-cycle strobe, smp_dat valid
// buf_adr    out  11  RAM write address {half, offset[9:0]}
// buf_dat    out  8   RAM write data
// buf_we     out  1   RAM write enable, one cycle per byte
// irq        out  1   level interrupt
// BEHAVIOUR
// - Reset: csr_do=0, buf_adr=0, buf_dat=0, buf_we=0, irq=0; all registers 0; state IDLE, half=0, offset=0.
// - CSR (selected when csr_a[14:10]==csr_addr). Read data is registered: 1 cycle. csr_do=0 when the bank is not selected.
//   0 CTRL    rw  [0] enable, [1] oneshot, [2] irq_en
//   1 STATUS  r/w1c [0] full0, [1] full1, [2] overflow; ro [3] active half, [5:4] state
//   2 COUNT   ro  32-bit count of bytes written since enable rose; wraps modulo 2^32
//   3 DROPPED ro  16-bit count of dropped strobes; saturates at 16'hFFFF; cleared when enable rises
// - FSM: IDLE, FILL, STALL.
//   IDLE: enable=1 -> FILL; half=0, offset=0.
//   FILL, smp_stb: next cycle buf_we=1, buf_adr={half,offset}, buf_dat=smp_dat; offset++.
//     On offset==1023 with strobe: set full[half], offset=0.
//       Oneshot and half==1 -> IDLE; enable cleared by hardware.
//       Else, full[~half]==0 -> half=~half, stay FILL.
//       Else -> STALL.
//   STALL: smp_stb dropped (no buf_we), overflow=1, DROPPED++. When full[~half] clears -> FILL with half=~half.
// - Write latency: 1 cycle from smp_stb to buf_we. Back-to-back strobes are legal (one write per cycle).
// - irq = irq_en & (full0 | full1 | overflow); registered, 1 cycle after the flag change.
// - Simultaneous HW set and CPU w1c of the same flag: set wins.
// - enable written 0 in any state: -> IDLE next cycle. A strobe in that same cycle is ignored.
//   half/offset reset to 0; full/overflow retained.
// - CSR writes to CTRL take effect the cycle after csr_we.
// - sys_rst mid-capture: all state returns to reset values on the next edge; an in-flight buf_we is cancelled.
// TESTING
// - Reset, then enable=1, 1024 strobes with data=addr[7:0] -> buf_adr 0..1023 in order, full0=1, half=1.
//   irq=1 if irq_en=1. COUNT=1024.
// - Continue 1024 strobes, no CPU clear -> full1=1, state STALL.
//   5 more strobes -> no buf_we, overflow=1, DROPPED=5.
// - In STALL, w1c full0 -> FILL half 0; next strobe writes buf_adr=0.
// - w1c full0 in the same cycle as its HW set -> full0 remains 1.
// - oneshot=1, 2048 strobes -> IDLE, CTRL.enable reads 0; further strobes produce no buf_we.
// - enable=0 at offset 500 -> IDLE, full flags unchanged.
//   Re-enable -> COUNT=0, first write at buf_adr=0.

Source files
------------

// File: rtl/gpsreceiver2_bufctl_if.sv
// Bus bundle for the GPS sample-RAM capture controller: CSR port, rx sample strobe,
// RAM write port and interrupt line.
interface gpsreceiver2_bufctl_if;
    logic [14:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic [7:0]  smp_dat;
    logic        smp_stb;
    logic [10:0] buf_adr;
    logic [7:0]  buf_dat;
    logic        buf_we;
    logic        irq;

    modport master (
        output csr_a, csr_we, csr_di, smp_dat, smp_stb,
        input  csr_do, buf_adr, buf_dat, buf_we, irq
    );

    modport slave (
        input  csr_a, csr_we, csr_di, smp_dat, smp_stb,
        output csr_do, buf_adr, buf_dat, buf_we, irq
    );
endinterface

// File: rtl/gpsreceiver2_bufctl.sv
// Ping-pong capture controller for the 2 KiB GPS sample RAM: fills two 1 KiB halves
// in turn, flags full halves to the CPU and stalls (counting drops) when both are unread.
module gpsreceiver2_bufctl #(
    parameter logic [4:0] csr_addr = 5'h0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    gpsreceiver2_bufctl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [9:0] LAST_OFFSET = 10'd1023;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state, state_n;
    logic        half, half_n;
    logic [9:0]  offset, offset_n;
    logic        enable, oneshot, irq_en;
    logic [1:0]  full;
    logic        overflow;
    logic [31:0] count;
    logic [15:0] dropped;

    logic        wr, drop, oneshot_done;
    logic [1:0]  hw_set;

    logic        vld_p1;
    logic [10:0] adr_p1;
    logic [7:0]  dat_p1;
    logic        irq_p1;
    logic [31:0] csr_do_p1;

    logic        sel, wr_ctrl, wr_stat, en_fall, en_rise, clr_ovf;
    logic [1:0]  clr_full;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign sel      = (bus.csr_a[14:10] == csr_addr);
    assign wr_ctrl  = bus.csr_we & sel & (bus.csr_a[1:0] == 2'd0);
    assign wr_stat  = bus.csr_we & sel & (bus.csr_a[1:0] == 2'd1);
    assign en_fall  = wr_ctrl & ~bus.csr_di[0];
    assign en_rise  = wr_ctrl & bus.csr_di[0] & ~enable;
    assign clr_full = wr_stat ? bus.csr_di[1:0] : 2'b00;
    assign clr_ovf  = wr_stat & bus.csr_di[2];

    assign unused_bits = ^{bus.csr_a[9:2], bus.csr_di[31:3]};

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (bus.csr_a[1:0])
                2'd0:    rd_data = {29'd0, irq_en, oneshot, enable};
                2'd1:    rd_data = {26'd0, state, half, overflow, full};
                2'd2:    rd_data = count;
                default: rd_data = {16'd0, dropped};
            endcase
        end
    end

    // A CPU disable overrides whatever the FSM would do with a strobe this cycle.
    always_comb begin
        state_n      = state;
        half_n       = half;
        offset_n     = offset;
        wr           = 1'b0;
        drop         = 1'b0;
        oneshot_done = 1'b0;
        hw_set       = 2'b00;
        if (en_fall) begin
            state_n  = IDLE;
            half_n   = 1'b0;
            offset_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state_n  = FILL;
                        half_n   = 1'b0;
                        offset_n = '0;
                    end
                end
                FILL: begin
                    if (bus.smp_stb) begin
                        wr = 1'b1;
                        if (offset == LAST_OFFSET) begin
                            hw_set[half] = 1'b1;
                            offset_n     = '0;
                            if (oneshot && half) begin
                                state_n      = IDLE;
                                half_n       = 1'b0;
                                oneshot_done = 1'b1;
                            end else if (!full[~half]) begin
                                half_n = ~half;
                            end else begin
                                state_n = STALL;
                            end
                        end else begin
                            offset_n = offset + 10'd1;
                        end
                    end
                end
                STALL: begin
                    drop = bus.smp_stb;
                    if (!full[~half]) begin
                        state_n = FILL;
                        half_n  = ~half;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            half      <= 1'b0;
            offset    <= '0;
            enable    <= 1'b0;
            oneshot   <= 1'b0;
            irq_en    <= 1'b0;
            full      <= 2'b00;
            overflow  <= 1'b0;
            count     <= '0;
            dropped   <= '0;
            vld_p1    <= 1'b0;
            adr_p1    <= '0;
            dat_p1    <= '0;
            irq_p1    <= 1'b0;
            csr_do_p1 <= '0;
        end else begin
            state  <= state_n;
            half   <= half_n;
            offset <= offset_n;
            if (wr_ctrl) begin
                enable  <= bus.csr_di[0];
                oneshot <= bus.csr_di[1];
                irq_en  <= bus.csr_di[2];
            end else if (oneshot_done) begin
                enable <= 1'b0;
            end
            // Hardware set takes priority over a same-cycle write-one-to-clear.
            full     <= (full & ~clr_full) | hw_set;
            overflow <= (overflow & ~clr_ovf) | drop;
            if (en_rise)
                count <= '0;
            else if (wr)
                count <= count + 32'd1;
            if (en_rise)
                dropped <= '0;
            else if (drop)
                dropped <= sat_inc16(dropped);
            // p1: RAM write stage, one cycle behind the strobe
            vld_p1 <= wr;
            if (wr) begin
                adr_p1 <= {half, offset};
                dat_p1 <= bus.smp_dat;
            end
            irq_p1    <= irq_en & ((|full) | overflow);
            csr_do_p1 <= rd_data;
        end
    end

    assign bus.buf_we  = vld_p1;
    assign bus.buf_adr = adr_p1;
    assign bus.buf_dat = dat_p1;
    assign bus.irq     = irq_p1;
    assign bus.csr_do  = csr_do_p1;
endmodule

// File: tb/tb_gpsreceiver2_bufctl.sv
// Randomized bench for gpsreceiver2_bufctl against a transaction-level model of the
// ping-pong capture rules (queue of expected RAM writes plus flag/counter state).
module tb_gpsreceiver2_bufctl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpsreceiver2_bufctl_if bus();

    gpsreceiver2_bufctl #(.csr_addr(5'h0)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: state 0=IDLE 1=FILL 2=STALL
    int          m_state;
    bit          m_half;
    int          m_off;
    bit [1:0]    m_full;
    bit          m_ovf;
    bit          m_en, m_os, m_ie;
    bit [31:0]   m_count;
    int          m_drop;
    logic [10:0] exp_adr[$];
    logic [7:0]  exp_dat[$];
    logic [10:0] act_adr[$];
    logic [7:0]  act_dat[$];

    always @(negedge clk) begin
        if (bus.buf_we === 1'b1) begin
            act_adr.push_back(bus.buf_adr);
            act_dat.push_back(bus.buf_dat);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0; m_half = 0; m_off = 0; m_full = 2'b00; m_ovf = 0;
        m_en = 0; m_os = 0; m_ie = 0; m_count = 0; m_drop = 0;
        exp_adr.delete(); exp_dat.delete();
        act_adr.delete(); act_dat.delete();
    endtask

    task automatic model_strobe(input logic [7:0] d);
        if (m_state == 1) begin
            exp_adr.push_back(11'(int'(m_half) * 1024 + m_off));
            exp_dat.push_back(d);
            m_count = m_count + 1;
            m_off = m_off + 1;
            if (m_off == 1024) begin
                m_full[m_half] = 1'b1;
                m_off = 0;
                if (m_os && m_half) begin
                    m_state = 0; m_en = 0; m_half = 0;
                end else if (!m_full[!m_half]) begin
                    m_half = !m_half;
                end else begin
                    m_state = 2;
                end
            end
        end else if (m_state == 2) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop = m_drop + 1;
        end
    endtask

    task automatic model_ctrl(input logic [31:0] d);
        if (!d[0]) begin
            m_state = 0; m_half = 0; m_off = 0;
        end else if (!m_en) begin
            m_count = 0; m_drop = 0; m_state = 1; m_half = 0; m_off = 0;
        end
        m_en = d[0]; m_os = d[1]; m_ie = d[2];
    endtask

    task automatic model_w1c(input logic [31:0] d);
        m_full = m_full & ~d[1:0];
        if (d[2]) m_ovf = 1'b0;
        if (m_state == 2 && !m_full[!m_half]) begin
            m_state = 1; m_half = !m_half;
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {26'd0, 2'(m_state), m_half, m_ovf, m_full};
    endfunction

    function automatic logic exp_irq();
        return m_ie & ((|m_full) | m_ovf);
    endfunction

    task automatic cyc(input logic stb, input logic [7:0] d, input logic we,
                       input logic [14:0] a, input logic [31:0] di);
        @(negedge clk);
        bus.smp_stb = stb; bus.smp_dat = d;
        bus.csr_we = we; bus.csr_a = a; bus.csr_di = di;
    endtask

    task automatic strobe(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 15'd0, 32'd0);
        model_strobe(d);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'd0, 1'b0, 15'd0, 32'd0);
    endtask

    task automatic maybe_gap();
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    endtask

    task automatic csr_wr(input logic [14:0] a, input logic [31:0] di);
        cyc(1'b0, 8'd0, 1'b1, a, di);
        cyc(1'b0, 8'd0, 1'b0, a, 32'd0);
        if (a == 15'd0) model_ctrl(di);
        else if (a == 15'd1) model_w1c(di);
    endtask

    task automatic csr_rd(input logic [14:0] a, output logic [31:0] d);
        cyc(1'b0, 8'd0, 1'b0, a, 32'd0);
        cyc(1'b0, 8'd0, 1'b0, a, 32'd0);
        d = bus.csr_do;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        idle(3);
        n_checks++; if (bus.buf_we !== 1'b0) $display("FAIL rst_buf_we got %b want 0", bus.buf_we); else n_pass++;
        n_checks++; if (bus.buf_adr !== 11'd0) $display("FAIL rst_buf_adr got %h want 0", bus.buf_adr); else n_pass++;
        n_checks++; if (bus.buf_dat !== 8'd0) $display("FAIL rst_buf_dat got %h want 0", bus.buf_dat); else n_pass++;
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL rst_irq got %b want 0", bus.irq); else n_pass++;
        n_checks++; if (bus.csr_do !== 32'd0) $display("FAIL rst_csr_do got %h want 0", bus.csr_do); else n_pass++;
        rst = 1'b0;
        model_reset();
        for (int r = 0; r < 4; r++) begin
            csr_rd(15'(r), rd);
            n_checks++; if (rd !== 32'd0) $display("FAIL rst_reg%0d got %h want 0", r, rd); else n_pass++;
        end
        // Another bank must neither respond nor accept writes.
        cyc(1'b0, 8'd0, 1'b1, 15'h0400, 32'h7);
        idle(1);
        csr_rd(15'h0400, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL other_bank_read got %h want 0", rd); else n_pass++;
        csr_rd(15'd0, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL other_bank_write_ctrl got %h want 0", rd); else n_pass++;
    endtask

    task automatic test_fill_half0();
        logic [31:0] rd;
        csr_wr(15'd0, 32'h5);
        for (int i = 0; i < 1024; i++) strobe(8'(i));
        idle(2);
        n_checks++;
        if (act_adr.size() !== exp_adr.size()) $display("FAIL fill0_nwrites got %0d want %0d", act_adr.size(), exp_adr.size()); else n_pass++;
        for (int i = 0; i < exp_adr.size() && i < act_adr.size(); i++) begin
            n_checks++;
            if (act_adr[i] !== exp_adr[i] || act_dat[i] !== exp_dat[i])
                $display("FAIL fill0_write[%0d] got %h/%h want %h/%h", i, act_adr[i], act_dat[i], exp_adr[i], exp_dat[i]);
            else n_pass++;
        end
        act_adr.delete(); act_dat.delete(); exp_adr.delete(); exp_dat.delete();
        csr_rd(15'd1, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL fill0_status got %h want %h", rd, exp_status()); else n_pass++;
        n_checks++; if (bus.irq !== exp_irq()) $display("FAIL fill0_irq got %b want %b", bus.irq, exp_irq()); else n_pass++;
        csr_rd(15'd2, rd);
        n_checks++; if (rd !== m_count) $display("FAIL fill0_count got %0d want %0d", rd, m_count); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] rd;
        for (int i = 0; i < 1024; i++) begin
            strobe(8'($urandom));
            maybe_gap();
        end
        for (int i = 0; i < 5; i++) strobe(8'($urandom));
        idle(2);
        n_checks++;
        if (act_adr.size() !== exp_adr.size()) $display("FAIL stall_nwrites got %0d want %0d", act_adr.size(), exp_adr.size()); else n_pass++;
        for (int i = 0; i < exp_adr.size() && i < act_adr.size(); i++) begin
            n_checks++;
            if (act_adr[i] !== exp_adr[i] || act_dat[i] !== exp_dat[i])
                $display("FAIL stall_write[%0d] got %h/%h want %h/%h", i, act_adr[i], act_dat[i], exp_adr[i], exp_dat[i]);
            else n_pass++;
        end
        act_adr.delete(); act_dat.delete(); exp_adr.delete(); exp_dat.delete();
        csr_rd(15'd1, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL stall_status got %h want %h", rd, exp_status()); else n_pass++;
        csr_rd(15'd3, rd);
        n_checks++; if (rd !== 32'(m_drop)) $display("FAIL stall_dropped got %0d want %0d", rd, m_drop); else n_pass++;
        n_checks++; if (bus.irq !== exp_irq()) $display("FAIL stall_irq got %b want %b", bus.irq, exp_irq()); else n_pass++;
    endtask

    task automatic test_w1c_resume();
        logic [31:0] rd;
        csr_wr(15'd1, 32'h1);
        csr_rd(15'd1, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL resume_status got %h want %h", rd, exp_status()); else n_pass++;
        strobe(8'hA5);
        idle(2);
        n_checks++;
        if (act_adr.size() !== 1 || exp_adr.size() !== 1) $display("FAIL resume_nwrites got %0d want %0d", act_adr.size(), exp_adr.size());
        else if (act_adr[0] !== exp_adr[0] || act_dat[0] !== exp_dat[0])
            $display("FAIL resume_write got %h/%h want %h/%h", act_adr[0], act_dat[0], exp_adr[0], exp_dat[0]);
        else n_pass++;
        act_adr.delete(); act_dat.delete(); exp_adr.delete(); exp_dat.delete();
    endtask

    task automatic test_set_wins();
        logic [31:0] rd;
        logic [7:0]  d;
        for (int i = 0; i < 1022; i++) begin
            strobe(8'($urandom));
            maybe_gap();
        end
        d = 8'($urandom);
        cyc(1'b1, d, 1'b1, 15'd1, 32'h1);
        model_w1c(32'h1);
        model_strobe(d);
        idle(2);
        n_checks++;
        if (act_adr.size() !== exp_adr.size()) $display("FAIL setwins_nwrites got %0d want %0d", act_adr.size(), exp_adr.size()); else n_pass++;
        for (int i = 0; i < exp_adr.size() && i < act_adr.size(); i++) begin
            n_checks++;
            if (act_adr[i] !== exp_adr[i] || act_dat[i] !== exp_dat[i])
                $display("FAIL setwins_write[%0d] got %h/%h want %h/%h", i, act_adr[i], act_dat[i], exp_adr[i], exp_dat[i]);
            else n_pass++;
        end
        act_adr.delete(); act_dat.delete(); exp_adr.delete(); exp_dat.delete();
        csr_rd(15'd1, rd);
        n_checks++; if (rd[0] !== 1'b1) $display("FAIL setwins_full0 got %b want 1", rd[0]); else n_pass++;
        n_checks++; if (rd !== exp_status()) $display("FAIL setwins_status got %h want %h", rd, exp_status()); else n_pass++;
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        csr_wr(15'd0, 32'h0);
        csr_wr(15'd1, 32'h7);
        csr_wr(15'd0, 32'h3);
        csr_rd(15'd3, rd);
        n_checks++; if (rd !== 32'(m_drop)) $display("FAIL oneshot_dropped_clr got %0d want %0d", rd, m_drop); else n_pass++;
        for (int i = 0; i < 2048; i++) begin
            strobe(8'($urandom));
            maybe_gap();
        end
        for (int i = 0; i < 4; i++) strobe(8'($urandom));
        idle(2);
        n_checks++;
        if (act_adr.size() !== exp_adr.size()) $display("FAIL oneshot_nwrites got %0d want %0d", act_adr.size(), exp_adr.size()); else n_pass++;
        for (int i = 0; i < exp_adr.size() && i < act_adr.size(); i++) begin
            n_checks++;
            if (act_adr[i] !== exp_adr[i] || act_dat[i] !== exp_dat[i])
                $display("FAIL oneshot_write[%0d] got %h/%h want %h/%h", i, act_adr[i], act_dat[i], exp_adr[i], exp_dat[i]);
            else n_pass++;
        end
        act_adr.delete(); act_dat.delete(); exp_adr.delete(); exp_dat.delete();
        csr_rd(15'd0, rd);
        n_checks++; if (rd !== {29'd0, m_ie, m_os, m_en}) $display("FAIL oneshot_ctrl got %h want %h", rd, {29'd0, m_ie, m_os, m_en}); else n_pass++;
        csr_rd(15'd1, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL oneshot_status got %h want %h", rd, exp_status()); else n_pass++;
        csr_rd(15'd2, rd);
        n_checks++; if (rd !== m_count) $display("FAIL oneshot_count got %0d want %0d", rd, m_count); else n_pass++;
        n_checks++; if (bus.irq !== exp_irq()) $display("FAIL oneshot_irq got %b want %b", bus.irq, exp_irq()); else n_pass++;
    endtask

    task automatic test_disable();
        logic [31:0] rd;
        csr_wr(15'd0, 32'h5);
        for (int i = 0; i < 500; i++) begin
            strobe(8'($urandom));
            maybe_gap();
        end
        // Disable with a strobe in the same cycle: the strobe must not be written.
        cyc(1'b1, 8'h3C, 1'b1, 15'd0, 32'h0);
        model_ctrl(32'h0);
        idle(2);
        n_checks++;
        if (act_adr.size() !== exp_adr.size()) $display("FAIL disable_nwrites got %0d want %0d", act_adr.size(), exp_adr.size()); else n_pass++;
        for (int i = 0; i < exp_adr.size() && i < act_adr.size(); i++) begin
            n_checks++;
            if (act_adr[i] !== exp_adr[i] || act_dat[i] !== exp_dat[i])
                $display("FAIL disable_write[%0d] got %h/%h want %h/%h", i, act_adr[i], act_dat[i], exp_adr[i], exp_dat[i]);
            else n_pass++;
        end
        act_adr.delete(); act_dat.delete(); exp_adr.delete(); exp_dat.delete();
        csr_rd(15'd1, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL disable_status got %h want %h", rd, exp_status()); else n_pass++;
        csr_wr(15'd0, 32'h5);
        csr_rd(15'd2, rd);
        n_checks++; if (rd !== m_count) $display("FAIL reenable_count got %0d want %0d", rd, m_count); else n_pass++;
        strobe(8'h5A);
        idle(2);
        n_checks++;
        if (act_adr.size() !== 1 || exp_adr.size() !== 1) $display("FAIL reenable_nwrites got %0d want %0d", act_adr.size(), exp_adr.size());
        else if (act_adr[0] !== exp_adr[0] || act_dat[0] !== exp_dat[0])
            $display("FAIL reenable_write got %h/%h want %h/%h", act_adr[0], act_dat[0], exp_adr[0], exp_dat[0]);
        else n_pass++;
        act_adr.delete(); act_dat.delete(); exp_adr.delete(); exp_dat.delete();
        n_checks++; if (bus.irq !== exp_irq()) $display("FAIL reenable_irq got %b want %b", bus.irq, exp_irq()); else n_pass++;
    endtask

    task automatic test_reset_midcapture();
        logic [31:0] rd;
        cyc(1'b1, 8'h77, 1'b0, 15'd0, 32'd0);
        rst = 1'b1;
        cyc(1'b0, 8'd0, 1'b0, 15'd0, 32'd0);
        n_checks++; if (bus.buf_we !== 1'b0) $display("FAIL midrst_buf_we got %b want 0", bus.buf_we); else n_pass++;
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL midrst_irq got %b want 0", bus.irq); else n_pass++;
        rst = 1'b0;
        model_reset();
        csr_rd(15'd1, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL midrst_status got %h want %h", rd, exp_status()); else n_pass++;
        csr_rd(15'd0, rd);
        n_checks++; if (rd !== {29'd0, m_ie, m_os, m_en}) $display("FAIL midrst_ctrl got %h want %h", rd, {29'd0, m_ie, m_os, m_en}); else n_pass++;
        csr_rd(15'd2, rd);
        n_checks++; if (rd !== m_count) $display("FAIL midrst_count got %0d want %0d", rd, m_count); else n_pass++;
        n_checks++; if (act_adr.size() !== 0) $display("FAIL midrst_nwrites got %0d want 0", act_adr.size()); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        bus.smp_stb = 1'b0; bus.smp_dat = 8'd0;
        bus.csr_we = 1'b0; bus.csr_a = 15'd0; bus.csr_di = 32'd0;
        model_reset();
        test_reset();
        test_fill_half0();
        test_stall();
        test_w1c_resume();
        test_set_wins();
        test_oneshot();
        test_disable();
        test_reset_midcapture();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
